// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator operation sequencer.
package calc_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned RESULT_W = 16;
    localparam int unsigned OP_W     = 3;
    localparam int unsigned PHASE_W  = 3;
    localparam int unsigned TMO_W    = 32;

    typedef enum logic [PHASE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_GET_A  = 3'd1,
        ST_GET_B  = 3'd2,
        ST_GET_OP = 3'd3,
        ST_EXEC   = 3'd4,
        ST_SHOW   = 3'd5
    } state_e;

    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_MUL = 3'd2;
    localparam logic [OP_W-1:0] OP_AND = 3'd3;
    localparam logic [OP_W-1:0] OP_OR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XOR = 3'd5;
    localparam logic [OP_W-1:0] OP_SHL = 3'd6;
    localparam logic [OP_W-1:0] OP_DIV = 3'd7;

endpackage

// File: rtl/calc_alu.sv
// Combinational ALU: one 8-bit x 8-bit operation producing a 16-bit result.
module calc_alu
    import calc_pkg::*;
(
    input  logic [DATA_W-1:0]   i_a,
    input  logic [DATA_W-1:0]   i_b,
    input  logic [OP_W-1:0]     i_op,
    output logic [RESULT_W-1:0] o_result,
    output logic                o_div_zero
);

    always_comb begin
        o_result   = '0;
        o_div_zero = 1'b0;
        case (i_op)
            OP_ADD: o_result = RESULT_W'(i_a) + RESULT_W'(i_b);
            OP_SUB: o_result = RESULT_W'(i_a) - RESULT_W'(i_b);
            OP_MUL: o_result = RESULT_W'(i_a) * RESULT_W'(i_b);
            OP_AND: o_result = RESULT_W'(i_a & i_b);
            OP_OR:  o_result = RESULT_W'(i_a | i_b);
            OP_XOR: o_result = RESULT_W'(i_a ^ i_b);
            OP_SHL: o_result = RESULT_W'(i_a) << i_b[3:0];
            OP_DIV: begin
                // Divide-by-zero saturates to all ones and flags the error.
                if (i_b == '0) begin
                    o_result   = '1;
                    o_div_zero = 1'b1;
                end else begin
                    o_result = {i_a % i_b, i_a / i_b};
                end
            end
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/calc_controller.sv
// Operation sequencer: collects A, B and opcode from the serial entry unit,
// executes one ALU operation and holds the result for the display stage.
module calc_controller
    import calc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_clear,
    input  logic [DATA_W-1:0]   i_value,
    input  logic                i_value_ready,
    output logic                o_input_enable,
    output logic [PHASE_W-1:0]  o_phase,
    output logic [RESULT_W-1:0] o_result,
    output logic                o_result_valid,
    output logic                o_error
);

    state_e              r_state;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [OP_W-1:0]     r_op;
    logic [RESULT_W-1:0] r_result;
    logic                r_result_valid;
    logic                r_error;
    logic [TMO_W-1:0]    r_tmo_cnt;

    logic [RESULT_W-1:0] w_alu_result;
    logic                w_div_zero;
    logic                w_collecting;
    logic                w_timeout;

    calc_alu u_alu (
        .i_a        (r_a),
        .i_b        (r_b),
        .i_op       (r_op),
        .o_result   (w_alu_result),
        .o_div_zero (w_div_zero)
    );

    assign w_collecting = (r_state == ST_GET_A) || (r_state == ST_GET_B) ||
                          (r_state == ST_GET_OP);
    assign w_timeout    = (TIMEOUT != 0) && w_collecting && !i_value_ready &&
                          (r_tmo_cnt == TMO_W'(TIMEOUT - 1));

    // Pure state decodes; no input reaches these outputs combinationally.
    assign o_phase        = r_state;
    assign o_input_enable = w_collecting;
    assign o_result       = r_result;
    assign o_result_valid = r_result_valid;
    assign o_error        = r_error;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_IDLE;
            r_a            <= '0;
            r_b            <= '0;
            r_op           <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_error        <= 1'b0;
            r_tmo_cnt      <= '0;
        end else begin
            r_result_valid <= 1'b0;
            // Counter restarts on every strobe and whenever a GET state is entered.
            r_tmo_cnt      <= (w_collecting && !i_value_ready) ? r_tmo_cnt + TMO_W'(1) : '0;
            if (i_clear) begin
                r_state <= ST_IDLE;
                r_error <= 1'b0;
            end else if (w_timeout) begin
                r_state <= ST_IDLE;
                r_error <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_start) begin
                            r_state  <= ST_GET_A;
                            r_error  <= 1'b0;
                            r_result <= '0;
                        end
                    end
                    ST_GET_A: begin
                        if (i_value_ready) begin
                            r_a     <= i_value;
                            r_state <= ST_GET_B;
                        end
                    end
                    ST_GET_B: begin
                        if (i_value_ready) begin
                            r_b     <= i_value;
                            r_state <= ST_GET_OP;
                        end
                    end
                    ST_GET_OP: begin
                        if (i_value_ready) begin
                            r_op <= i_value[OP_W-1:0];
                            if (|i_value[DATA_W-1:OP_W]) begin
                                r_error        <= 1'b1;
                                r_result       <= '0;
                                r_result_valid <= 1'b1;
                                r_state        <= ST_SHOW;
                            end else begin
                                r_state <= ST_EXEC;
                            end
                        end
                    end
                    ST_EXEC: begin
                        r_result       <= w_alu_result;
                        r_error        <= r_error | w_div_zero;
                        r_result_valid <= 1'b1;
                        r_state        <= ST_SHOW;
                    end
                    ST_SHOW: begin
                        if (i_start) begin
                            r_state <= ST_GET_A;
                            r_error <= 1'b0;
                        end else begin
                            r_result_valid <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/calc_controller.md
# calc_controller

Operation sequencer directly downstream of the 8-bit serial entry unit. It consumes the entry unit's `value`/`value_ready` pulses as operand A, operand B and an opcode, executes one arithmetic/logic operation, and holds the 16-bit result for the display stage. It also drives the entry unit's `enable`, so partial entries are flushed whenever the controller is not collecting.

## Interface
- `TIMEOUT`, default 0: cycles without a `value_ready` pulse in a collect state before aborting. 0 disables the timeout.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse; begins a new calculation.
- `clear` in 1: single-cycle pulse; abort to IDLE.
- `value` in 8: byte from the entry unit.
- `value_ready` in 1: single-cycle strobe; `value` is valid in that cycle.
- `input_enable` out 1: drives the entry unit's `enable`.
- `phase` out 3: current state encoding, for LEDs.
- `result` out 16: computed result.
- `result_valid` out 1: high while in SHOW.
- `error` out 1: sticky until the next `start`/`clear`; set on bad opcode, divide-by-zero or timeout.

## Operation
- States and encodings: IDLE=0, GET_A=1, GET_B=2, GET_OP=3, EXEC=4, SHOW=5.
- IDLE: `input_enable`=0. `start` -> GET_A, clearing `error` and `result`.
- GET_A: `input_enable`=1. `value_ready` latches A -> GET_B.
- GET_B: `input_enable`=1. `value_ready` latches B -> GET_OP.
- GET_OP: `input_enable`=1. `value_ready` latches op=`value[2:0]` -> EXEC. If `value[7:3]`≠0, set `error`, write `result`=0 and go -> SHOW, skipping EXEC.
- EXEC: `input_enable`=0. Takes one cycle, writes `result`, -> SHOW.
- SHOW: `input_enable`=0, `result_valid`=1. `start` -> GET_A, clearing `error`. `clear` -> IDLE.
- Opcodes:
  - 0: A+B, zero-extended to 16 bits.
  - 1: A−B, 16-bit two's complement. Wraps, e.g. 3−5 = 0xFFFE.
  - 2: A×B, 16-bit unsigned.
  - 3: A&B, 4: A|B, 5: A^B, each zero-extended.
  - 6: {8'd0,A} << B[3:0], truncated to 16 bits.
  - 7: {remainder, quotient} of A/B, unsigned. If B=0: `result`=0xFFFF and `error` is set.
- Priority: `clear` beats everything. `clear` and `value_ready` in the same cycle -> IDLE, byte discarded.
- `start` is ignored in GET_*/EXEC.
- `value_ready` is ignored in IDLE/EXEC/SHOW.
- Timeout:
  - A counter resets on entry to each GET_* state and on each `value_ready`.
  - When it reaches `TIMEOUT` (nonzero): -> IDLE with `error`=1, and `result` is unchanged.

## Timing
- Reset values: state IDLE, `input_enable`=0, `phase`=0, `result`=0, `result_valid`=0, `error`=0, A/B/op=0.
- All outputs are registered except `phase` and `input_enable`. These two decode the state register directly, with no combinational path from inputs.
- Opcode `value_ready` at edge N -> EXEC during cycle N+1 -> `result`/`result_valid` valid after edge N+2.
- `input_enable` stays high continuously across GET_A->GET_B->GET_OP; the entry unit clears its own bit count on each strobe.
- `input_enable` falls in the cycle after the opcode strobe, so the entry unit flushes.
- Reset mid-operation: immediately to the reset values above. A partial operand is lost.

## Structure
- Package `calc_pkg`:
  - state enum/localparams;
  - opcode localparams OP_ADD..OP_DIV;
  - RESULT_W=16.
- Sub-module `calc_alu`: purely combinational. Inputs A, B, op; outputs 16-bit result and div_zero.
- The controller registers `calc_alu`'s outputs in EXEC.

## Test plan
- Add path: `start`; bytes 0x12, 0x34, 0x00 -> `result`=0x0046, `result_valid`=1 two edges after the third strobe, `error`=0.
- Sub wrap and mul: 0x03, 0x05, op 1 -> 0xFFFE. Then `start`; 0xFF, 0xFF, op 2 -> 0xFE01.
- Divide: 0x64, 0x07, op 7 -> 0x020E. Then 0x10, 0x00, op 7 -> 0xFFFF with `error`=1.
- Bad opcode 0x09 -> SHOW, `result`=0, `error`=1, and no EXEC cycle occurs.
- `clear` in GET_B coincident with `value_ready` -> IDLE, `input_enable`=0, byte discarded. Then `start` -> `error` cleared, back in GET_A.
- `TIMEOUT`=10: `start`, no strobes -> after 10 cycles IDLE with `error`=1. Also check that asserting `rst` low in EXEC forces all outputs to their reset values asynchronously.
